// File: rtl/os_array_scheduler.sv
// Job sequencer for an output-stationary systolic array: clear, activation load,
// compute wavefront and handshaked row drain, driving the array's shared control nets.
module os_array_scheduler #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int STAGE = 0,
  parameter int K_W   = 8,
  parameter int CNT_W = K_W + 4,
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [K_W-1:0]  k_len,
  input  logic            abort,
  input  logic            stall,
  input  logic            drain_ready,
  output logic            busy,
  output logic            done,
  output logic            reg_clear,
  output logic            pipeline_en,
  output logic [ROWS-1:0] cell_en,
  output logic [ROWS-1:0] cell_sc_en,
  output logic            cscan_en,
  output logic            drain_valid,
  output logic [RW-1:0]   drain_row
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [K_W-1:0]   kLen_q, kLen_d;
  logic [RW-1:0]    loadCnt_q, loadCnt_d;
  logic [CNT_W-1:0] computeCnt_q, computeCnt_d;
  logic [RW-1:0]    rowCnt_q, rowCnt_d;
  logic             abortPend_q, abortPend_d;

  logic            busy_q, done_q, regClear_q, compute_q, cscanEn_q;
  logic [ROWS-1:0] cellEn_q, cellEn_d, cellScEn_q, cellScEn_d;
  logic [RW-1:0]   drainRow_q;

  logic [CNT_W-1:0] window;
  logic [CNT_W-1:0] total;

  assign window = CNT_W'(kLen_q) + CNT_W'(COLS + STAGE - 1);
  assign total  = window + CNT_W'(ROWS - 1);

  always_comb begin
    state_d      = state_q;
    kLen_d       = kLen_q;
    loadCnt_d    = loadCnt_q;
    computeCnt_d = computeCnt_q;
    rowCnt_d     = rowCnt_q;
    abortPend_d  = abortPend_q;
    case (state_q)
      S_IDLE: begin
        if (start && (k_len != '0)) begin
          state_d     = S_CLEAR;
          kLen_d      = k_len;
          abortPend_d = 1'b0;
        end
      end
      S_CLEAR: begin
        if (abortPend_q || abort) begin
          state_d     = S_IDLE;
          abortPend_d = 1'b0;
        end else begin
          state_d   = S_LOAD;
          loadCnt_d = '0;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d     = S_CLEAR;
          abortPend_d = 1'b1;
        end else if (loadCnt_q == RW'(ROWS - 1)) begin
          state_d      = S_COMPUTE;
          computeCnt_d = '0;
        end else begin
          loadCnt_d = loadCnt_q + 1'b1;
        end
      end
      S_COMPUTE: begin
        if (abort) begin
          state_d     = S_CLEAR;
          abortPend_d = 1'b1;
        end else if (!stall) begin
          if (computeCnt_q == total - 1'b1) begin
            state_d  = S_DRAIN;
            rowCnt_d = '0;
          end else begin
            computeCnt_d = computeCnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d     = S_CLEAR;
          abortPend_d = 1'b1;
        end else if (drain_ready) begin
          if (rowCnt_q == RW'(ROWS - 1)) begin
            state_d = S_DONE;
          end else begin
            rowCnt_d = rowCnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (abort) begin
          state_d     = S_CLEAR;
          abortPend_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) begin
      loadCnt_d    = '0;
      computeCnt_d = '0;
      rowCnt_d     = '0;
    end
  end

  // Outputs are decoded from the next state and counters so they line up with state_q.
  always_comb begin
    cellEn_d   = '0;
    cellScEn_d = '0;
    for (int r = 0; r < ROWS; r++) begin
      cellScEn_d[r] = (state_d == S_LOAD) && (loadCnt_d == RW'(r));
      cellEn_d[r]   = (state_d == S_COMPUTE) && (computeCnt_d >= CNT_W'(r)) &&
                      (computeCnt_d < CNT_W'(r) + window);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      kLen_q       <= '0;
      loadCnt_q    <= '0;
      computeCnt_q <= '0;
      rowCnt_q     <= '0;
      abortPend_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      regClear_q   <= 1'b0;
      compute_q    <= 1'b0;
      cscanEn_q    <= 1'b0;
      cellEn_q     <= '0;
      cellScEn_q   <= '0;
      drainRow_q   <= '0;
    end else begin
      state_q      <= state_d;
      kLen_q       <= kLen_d;
      loadCnt_q    <= loadCnt_d;
      computeCnt_q <= computeCnt_d;
      rowCnt_q     <= rowCnt_d;
      abortPend_q  <= abortPend_d;
      busy_q       <= (state_d != S_IDLE);
      done_q       <= (state_d == S_DONE);
      regClear_q   <= (state_d == S_CLEAR);
      compute_q    <= (state_d == S_COMPUTE);
      cscanEn_q    <= (state_d == S_DRAIN);
      cellEn_q     <= cellEn_d;
      cellScEn_q   <= cellScEn_d;
      drainRow_q   <= (state_d == S_DRAIN) ? rowCnt_d : '0;
    end
  end

  // The pipeline must freeze in the very cycle the feeder stalls, so stall gates a registered flag.
  assign pipeline_en = compute_q & ~stall;
  assign busy        = busy_q;
  assign done        = done_q;
  assign reg_clear   = regClear_q;
  assign cell_en     = cellEn_q;
  assign cell_sc_en  = cellScEn_q;
  assign cscan_en    = cscanEn_q;
  assign drain_valid = cscanEn_q;
  assign drain_row   = drainRow_q;

endmodule
